// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hazard_ctrl_pkg                                        |
// | Description : Shared codes, slot types and match helpers for the     |
// |               pipeline hazard controller.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package hazard_ctrl_pkg;

  // Operand is not read by this instruction
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Operand select codes
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_PC8   = 2'b11;

  // Multiply/divide operation classes
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_HILO = 2'b11;

  // Instruction shadow held while it sits in EX
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md;
    logic       is_div;
  } ex_slot_t;

  // Instruction shadow held while it sits in MEM
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } mem_slot_t;

  // A source must wait when an in-flight producer of it finishes too late.
  // A destination of $0 can never match because src is non-zero here.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] ex_dst,
    input logic [1:0] ex_tnew,
    input logic [4:0] mem_dst,
    input logic [1:0] mem_tnew
  );
    logic hit;
    hit = 1'b0;
    if ((src != 5'd0) && (tuse != TUSE_NONE)) begin
      if ((ex_dst == src) && (ex_tnew > tuse)) hit = 1'b1;
      if ((mem_dst == src) && (mem_tnew > tuse)) hit = 1'b1;
    end
    return hit;
  endfunction

  // ID-stage select: youngest ready producer wins
  function automatic logic [1:0] fwd_id_sel(
    input logic [4:0] src,
    input logic [4:0] ex_dst,
    input logic [1:0] ex_tnew,
    input logic [4:0] mem_dst,
    input logic [1:0] mem_tnew,
    input logic [4:0] wb_dst
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if ((ex_dst == src) && (ex_tnew == 2'd0))        sel = FWD_PC8;
      else if ((mem_dst == src) && (mem_tnew == 2'd0)) sel = FWD_EXMEM;
      else if (wb_dst == src)                          sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  // EX-stage select: only MEM and WB are older than EX
  function automatic logic [1:0] fwd_ex_sel(
    input logic [4:0] src,
    input logic [4:0] mem_dst,
    input logic [1:0] mem_tnew,
    input logic [4:0] wb_dst
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if ((mem_dst == src) && (mem_tnew == 2'd0)) sel = FWD_EXMEM;
      else if (wb_dst == src)                     sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : md_busy_counter                                        |
// | Description : Busy countdown for the multi-cycle multiply/divide     |
// |               unit.                                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

  localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_count;

  // A new operation reloads over any countdown already in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= is_div ? c_div_load : c_mult_load;
    end else if (r_count != '0) begin
      r_count <= r_count - c_one;
    end
  end

  assign busy = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hazard_ctrl                                            |
// | Description : Stall, forwarding and MDU sequencing control for the   |
// |               five-stage pipeline.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_tuse_rs,
  input  logic [1:0] id_tuse_rt,
  input  logic [4:0] id_dst,
  input  logic [1:0] id_tnew,
  input  logic [1:0] id_md_op,
  output logic       stall,
  output logic [1:0] fwd_id_rs,
  output logic [1:0] fwd_id_rt,
  output logic [1:0] fwd_ex_rs,
  output logic [1:0] fwd_ex_rt,
  output logic       md_start,
  output logic       md_busy
);

  ex_slot_t   r_ex;
  mem_slot_t  r_mem;
  logic [4:0] r_wb_dst;

  logic w_md_busy;
  logic w_data_stall;
  logic w_md_stall;

  // Shadow slots advance with the pipeline; a stall turns EX into a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb_dst <= '0;
    end else begin
      r_mem.dst  <= r_ex.dst;
      r_mem.tnew <= (r_ex.tnew == 2'd0) ? 2'd0 : (r_ex.tnew - 2'd1);
      r_wb_dst   <= r_mem.dst;
      if (stall) begin
        r_ex <= '0;
      end else begin
        r_ex.dst    <= id_dst;
        r_ex.tnew   <= id_tnew;
        r_ex.rs     <= id_rs;
        r_ex.rt     <= id_rt;
        r_ex.md     <= (id_md_op == MD_MULT) || (id_md_op == MD_DIV);
        r_ex.is_div <= (id_md_op == MD_DIV);
      end
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (r_ex.md),
    .is_div (r_ex.is_div),
    .busy   (w_md_busy)
  );

  // Stall terms: operand not ready in time, or MDU still occupied
  always_comb begin
    w_data_stall = src_hazard(id_rs, id_tuse_rs, r_ex.dst, r_ex.tnew, r_mem.dst, r_mem.tnew)
                 | src_hazard(id_rt, id_tuse_rt, r_ex.dst, r_ex.tnew, r_mem.dst, r_mem.tnew);
    w_md_stall   = (id_md_op != MD_NONE) && (r_ex.md || w_md_busy);
  end

  // Stall and operand selects are purely combinational from the slots
  always_comb begin
    stall     = w_data_stall | w_md_stall;
    fwd_id_rs = fwd_id_sel(id_rs, r_ex.dst, r_ex.tnew, r_mem.dst, r_mem.tnew, r_wb_dst);
    fwd_id_rt = fwd_id_sel(id_rt, r_ex.dst, r_ex.tnew, r_mem.dst, r_mem.tnew, r_wb_dst);
    fwd_ex_rs = fwd_ex_sel(r_ex.rs, r_mem.dst, r_mem.tnew, r_wb_dst);
    fwd_ex_rt = fwd_ex_sel(r_ex.rt, r_mem.dst, r_mem.tnew, r_wb_dst);
    md_start  = r_ex.md;
    md_busy   = w_md_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                         |
// | Description : Self-checking bench for hazard_ctrl with an age-based  |
// |               readiness model and directed pipeline scenarios.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew, id_md_op;
  logic       stall, md_start, md_busy;
  logic [1:0] fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_tuse_rs (id_tuse_rs),
    .id_tuse_rt (id_tuse_rt),
    .id_dst     (id_dst),
    .id_tnew    (id_tnew),
    .id_md_op   (id_md_op),
    .stall      (stall),
    .fwd_id_rs  (fwd_id_rs),
    .fwd_id_rt  (fwd_id_rt),
    .fwd_ex_rs  (fwd_ex_rs),
    .fwd_ex_rt  (fwd_ex_rt),
    .md_start   (md_start),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[a] is the instruction that entered EX a cycles ago, with its
  // original tnew. Its result is usable once a >= tnew.
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] op;
  } m_instr_t;

  m_instr_t hist [0:2] = '{default: '0};
  int cyc      = 0;
  int busy_end = -1;

  function automatic bit is_mdu(input logic [1:0] op);
    return (op == 2'b01) || (op == 2'b10);
  endfunction

  function automatic bit m_busy();
    return cyc <= busy_end;
  endfunction

  // Consumer reads at cycle now+tuse; producer ready at entry+tnew.
  function automatic bit m_src_stall(input logic [4:0] s, input logic [1:0] tuse);
    if (s == 5'd0 || tuse == 2'd3) return 1'b0;
    for (int a = 0; a < 2; a++)
      if (hist[a].dst == s && int'(hist[a].tnew) > a + int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return m_src_stall(id_rs, id_tuse_rs) || m_src_stall(id_rt, id_tuse_rt) ||
           (id_md_op != 2'b00 && (is_mdu(hist[0].op) || m_busy()));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] s, input int first_age);
    if (s == 5'd0) return 2'b00;
    for (int a = first_age; a < 3; a++) begin
      if (hist[a].dst == s && int'(hist[a].tnew) <= a) begin
        if (a == 0) return 2'b11;
        if (a == 1) return 2'b01;
        return 2'b10;
      end
    end
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit s;
    if (!reset) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      busy_end = -1;
    end else begin
      s = m_stall();
      if (is_mdu(hist[0].op))
        busy_end = cyc + ((hist[0].op == 2'b10) ? DIV_N : MULT_N);
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (s) hist[0] = '0;
      else   hist[0] = {id_dst, id_tnew, id_rs, id_rt, id_md_op};
      cyc++;
    end
  end

  // Every cycle, all outputs against the model
  always @(negedge clk) begin
    check("stall",     stall,     m_stall());
    check("fwd_id_rs", fwd_id_rs, m_fwd(id_rs, 0));
    check("fwd_id_rt", fwd_id_rt, m_fwd(id_rt, 0));
    check("fwd_ex_rs", fwd_ex_rs, m_fwd(hist[0].rs, 1));
    check("fwd_ex_rt", fwd_ex_rt, m_fwd(hist[0].rt, 1));
    check("md_start",  md_start,  is_mdu(hist[0].op));
    check("md_busy",   md_busy,   m_busy());
  end

  // ---------------- stimulus ----------------
  task automatic set_nop();
    id_rs = 0; id_rt = 0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3;
    id_dst = 0; id_tnew = 0; id_md_op = 0;
  endtask

  task automatic flush(input int n);
    set_nop();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID and hold it until it advances.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tr, input logic [1:0] tt,
                       input logic [4:0] dst, input logic [1:0] tnew,
                       input logic [1:0] op,
                       output int n_stall, output int n_busy,
                       output int n_start, output logic [1:0] fwd_rs);
    bit done;
    id_rs = rs; id_rt = rt; id_tuse_rs = tr; id_tuse_rt = tt;
    id_dst = dst; id_tnew = tnew; id_md_op = op;
    n_stall = 0; n_busy = 0; n_start = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (md_busy)  n_busy++;
      if (md_start) n_start++;
      if (!stall) done = 1;
      else        n_stall++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: stall still %0d after 40 cycles", stall);
    end
    fwd_rs = fwd_id_rs;
    @(posedge clk);
    #1;
    set_nop();
  endtask

  int ns, nb, nst;
  logic [1:0] fw;

  initial begin
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", stall, 0);
    check("reset_busy",  md_busy, 0);
    reset = 1'b1;
    flush(3);

    // lw $8 ; addu rs=$8 tuse 1
    issue(29, 0, 1, 3, 8, 2, 2'b00, ns, nb, nst, fw);
    check("lw_no_stall", ns, 0);
    issue(8, 9, 1, 1, 10, 1, 2'b00, ns, nb, nst, fw);
    check("loaduse_stall_len", ns, 1);
    @(negedge clk);
    check("loaduse_fwd_ex_rs", fwd_ex_rs, 2'b10);
    flush(4);

    // ALU back to back, EX use: no stall, EX/MEM forward
    issue(1, 2, 1, 1, 3, 1, 2'b00, ns, nb, nst, fw);
    issue(3, 0, 1, 3, 4, 1, 2'b00, ns, nb, nst, fw);
    check("alu_alu_stall_len", ns, 0);
    @(negedge clk);
    check("alu_alu_fwd_ex_rs", fwd_ex_rs, 2'b01);
    flush(4);

    // addu $9 ; beq rs=$9 tuse 0
    issue(1, 2, 1, 1, 9, 1, 2'b00, ns, nb, nst, fw);
    issue(9, 0, 0, 3, 0, 1, 2'b00, ns, nb, nst, fw);
    check("branch_alu_stall_len", ns, 1);
    check("branch_alu_fwd_id_rs", fw, 2'b01);
    flush(4);

    // lw $12 ; beq rs=$12 tuse 0
    issue(29, 0, 1, 3, 12, 2, 2'b00, ns, nb, nst, fw);
    issue(12, 0, 0, 3, 0, 1, 2'b00, ns, nb, nst, fw);
    check("branch_load_stall_len", ns, 2);
    check("branch_load_fwd_id_rs", fw, 2'b10);
    flush(4);

    // jal ; jr $31
    issue(0, 0, 3, 3, 31, 0, 2'b00, ns, nb, nst, fw);
    issue(31, 0, 0, 3, 0, 1, 2'b00, ns, nb, nst, fw);
    check("jr_stall_len", ns, 0);
    check("jr_fwd_id_rs", fw, 2'b11);
    flush(4);

    // mult ; mflo
    issue(4, 5, 1, 1, 0, 1, 2'b01, ns, nb, nst, fw);
    issue(0, 0, 3, 3, 2, 1, 2'b11, ns, nb, nst, fw);
    check("mult_stall_len", ns, MULT_N + 1);
    check("mult_busy_len",  nb, MULT_N);
    check("mult_start_len", nst, 1);
    flush(4);

    // div ; mfhi
    issue(4, 5, 1, 1, 0, 1, 2'b10, ns, nb, nst, fw);
    issue(0, 0, 3, 3, 3, 1, 2'b11, ns, nb, nst, fw);
    check("div_stall_len", ns, DIV_N + 1);
    check("div_busy_len",  nb, DIV_N);
    flush(4);

    // lw $0 ; use of $0
    issue(29, 0, 1, 3, 0, 2, 2'b00, ns, nb, nst, fw);
    issue(0, 0, 0, 0, 5, 1, 2'b00, ns, nb, nst, fw);
    check("r0_stall_len", ns, 0);
    check("r0_fwd_id_rs", fw, 2'b00);
    flush(4);

    // div, mfhi waiting, reset dropped with three busy cycles left
    issue(4, 5, 1, 1, 0, 1, 2'b10, ns, nb, nst, fw);
    id_md_op = 2'b11; id_dst = 3; id_tnew = 1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("div_busy_before_reset",  md_busy, 1);
    check("div_stall_before_reset", stall, 1);
    #1;
    reset = 1'b0;
    #1;
    check("reset_async_busy",  md_busy, 0);
    check("reset_async_stall", stall, 0);
    check("reset_async_start", md_start, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    flush(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
